// File: rtl/mem_sched_pkg.sv
// Shared constants, state encoding and client indices for the memory access scheduler.
package mem_sched_pkg;

    localparam int DATA_W       = 8;
    localparam int DEPTH        = 8;
    localparam int ADDR_W       = 3;
    localparam int STARVE_LIMIT = 4;

    // Wide enough to hold 0..STARVE_LIMIT.
    localparam int STARVE_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sum_state_t;

    // Bit positions inside the one-hot grant vector {sum, c1, c0}.
    localparam int CLIENT0  = 0;
    localparam int CLIENT1  = 1;
    localparam int SUM_PORT = 2;

endpackage

// File: rtl/mem_access_sched_if.sv
// Client and sum-engine signal bundle for the memory access scheduler.
interface mem_access_sched_if;
    import mem_sched_pkg::*;

    logic              c0_req;
    logic              c0_we;
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic              c0_gnt;
    logic              c0_rvalid;
    logic [DATA_W-1:0] c0_rdata;

    logic              c1_req;
    logic              c1_we;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_gnt;
    logic              c1_rvalid;
    logic [DATA_W-1:0] c1_rdata;

    logic              start;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] ans;

    modport master (
        output c0_req, c0_we, c0_addr, c0_wdata,
        output c1_req, c1_we, c1_addr, c1_wdata,
        output start,
        input  c0_gnt, c0_rvalid, c0_rdata,
        input  c1_gnt, c1_rvalid, c1_rdata,
        input  busy, done, ans
    );

    modport slave (
        input  c0_req, c0_we, c0_addr, c0_wdata,
        input  c1_req, c1_we, c1_addr, c1_wdata,
        input  start,
        output c0_gnt, c0_rvalid, c0_rdata,
        output c1_gnt, c1_rvalid, c1_rdata,
        output busy, done, ans
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-client round-robin arbiter with a lower-priority sum requester and a
// force input that lets a starved sum engine pre-empt both clients.
module rr_arb2
    import mem_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       req_sum,
    input  logic       force_sum,
    output logic [2:0] gnt
);

    // High when client 1 should win the next tie (client 0 was served last).
    logic ptr;

    // Pick at most one winner: forced sum, then clients, then an idle-slot sum.
    always_comb begin
        gnt = '0;
        if (force_sum) begin
            gnt[SUM_PORT] = 1'b1;
        end else if (req0 && req1) begin
            if (ptr) begin
                gnt[CLIENT1] = 1'b1;
            end else begin
                gnt[CLIENT0] = 1'b1;
            end
        end else if (req0) begin
            gnt[CLIENT0] = 1'b1;
        end else if (req1) begin
            gnt[CLIENT1] = 1'b1;
        end else if (req_sum) begin
            gnt[SUM_PORT] = 1'b1;
        end
    end

    // Move the preference away from whichever client was just served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (gnt[CLIENT0]) begin
            ptr <= 1'b1;
        end else if (gnt[CLIENT1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_sched.sv
// Single-port memory shared by two clients and an internal sum engine; one
// access is committed per clock, chosen by the rr_arb2 arbiter.
module mem_access_sched
    import mem_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mem_access_sched_if.slave   bus
);

    logic [DATA_W-1:0]   mem [DEPTH];
    sum_state_t          state;
    sum_state_t          state_next;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   ans_q;
    logic [STARVE_W-1:0] starve_cnt;
    logic [2:0]          gnt;
    logic                scanning;
    logic                force_sum;
    logic                sum_gnt;
    logic                last_idx;
    logic [DATA_W-1:0]   sum_value;

    assign scanning  = (state == SCAN);
    assign force_sum = scanning && (starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign sum_gnt   = gnt[SUM_PORT];
    assign last_idx  = (idx == ADDR_W'(DEPTH - 1));
    assign sum_value = acc + mem[idx];

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req0      (bus.c0_req),
        .req1      (bus.c1_req),
        .req_sum   (scanning),
        .force_sum (force_sum),
        .gnt       (gnt)
    );

    assign bus.c0_gnt = gnt[CLIENT0];
    assign bus.c1_gnt = gnt[CLIENT1];
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.ans    = ans_q;

    // Commit the granted client write into the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (gnt[CLIENT0] && bus.c0_we) begin
            mem[bus.c0_addr] <= bus.c0_wdata;
        end else if (gnt[CLIENT1] && bus.c1_we) begin
            mem[bus.c1_addr] <= bus.c1_wdata;
        end
    end

    // Return granted client reads one cycle later; rdata holds afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.c0_rvalid <= 1'b0;
            bus.c0_rdata  <= '0;
            bus.c1_rvalid <= 1'b0;
            bus.c1_rdata  <= '0;
        end else begin
            bus.c0_rvalid <= gnt[CLIENT0] && !bus.c0_we;
            bus.c1_rvalid <= gnt[CLIENT1] && !bus.c1_we;
            if (gnt[CLIENT0] && !bus.c0_we) begin
                bus.c0_rdata <= mem[bus.c0_addr];
            end
            if (gnt[CLIENT1] && !bus.c1_we) begin
                bus.c1_rdata <= mem[bus.c1_addr];
            end
        end
    end

    // Sum engine state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sum engine sequencing: start only from IDLE, finish on the last read.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SCAN;
            SCAN:    if (sum_gnt && last_idx) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accumulate one entry per sum grant and publish the total on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= '0;
            acc   <= '0;
            ans_q <= '0;
        end else if (state == IDLE && bus.start) begin
            idx <= '0;
            acc <= '0;
        end else if (sum_gnt) begin
            acc <= sum_value;
            if (last_idx) begin
                ans_q <= sum_value;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Count consecutive denied scan cycles so a busy client pair cannot starve the sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (sum_gnt || !scanning) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
